// File: rtl/ising_job_sched.sv
// Job scheduler for a bank of Ising cores: a descriptor FIFO feeds idle cores
// round-robin, each core walks IDLE -> START -> RUN -> REPORT, and completions
// (done or timeout) are reported one at a time over a valid/ready channel.
module ising_job_sched #(
  parameter int NumCores     = 4,
  parameter int JobWidth     = 32,
  parameter int QueueDepth   = 4,
  parameter int TimeoutWidth = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  input  logic [TimeoutWidth-1:0]         timeout_i,
  input  logic                            job_valid_i,
  output logic                            job_ready_o,
  input  logic [JobWidth-1:0]             job_data_i,
  output logic [NumCores-1:0]             core_start_o,
  output logic [JobWidth-1:0]             core_job_o,
  output logic [NumCores-1:0]             core_abort_o,
  input  logic [NumCores-1:0]             core_done_i,
  output logic                            done_valid_o,
  input  logic                            done_ready_i,
  output logic [$clog2(NumCores)-1:0]     done_core_o,
  output logic                            done_timeout_o,
  output logic [$clog2(QueueDepth):0]     queue_cnt_o,
  output logic                            idle_o
);

  localparam int CoreW = $clog2(NumCores);
  localparam int PtrW  = $clog2(QueueDepth);
  localparam int CntW  = PtrW + 1;

  typedef enum logic [1:0] {IDLE, START, RUN, REPORT} core_state_t;

  // Job queue storage and bookkeeping
  logic [JobWidth-1:0] queue_mem [QueueDepth];
  logic [PtrW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]     count_reg;
  logic [JobWidth-1:0] start_job_reg;
  logic                push;

  // Dispatch arbitration
  logic [CoreW-1:0]    rr_ptr_reg;
  logic [CoreW-1:0]    disp_idx, disp_cand;
  logic                disp_found, dispatch;

  // Report arbitration and the latched report
  logic [CoreW-1:0]    rep_ptr_reg;
  logic [CoreW-1:0]    rep_idx, rep_cand;
  logic                rep_found, release_rep;
  logic                done_valid_reg, done_tmo_reg;
  logic [CoreW-1:0]    done_core_reg;

  // Per-core status gathered from the core FSMs
  logic [NumCores-1:0] idle_vec, report_vec, tmo_vec;

  assign job_ready_o    = (count_reg < CntW'(QueueDepth));
  assign push           = job_valid_i && job_ready_o;
  assign queue_cnt_o    = count_reg;
  assign core_job_o     = start_job_reg;
  assign done_valid_o   = done_valid_reg;
  assign done_core_o    = done_core_reg;
  assign done_timeout_o = done_tmo_reg;
  assign idle_o         = (count_reg == '0) && (&idle_vec);
  assign release_rep    = done_valid_reg && done_ready_i;

  // Pick the first idle core at or after rr_ptr, wrapping around
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    disp_cand  = '0;
    for (int i = 0; i < NumCores; i++) begin
      disp_cand = CoreW'((int'(rr_ptr_reg) + i) % NumCores);
      if (!disp_found && idle_vec[disp_cand]) begin
        disp_found = 1'b1;
        disp_idx   = disp_cand;
      end
    end
    dispatch = en_i && (count_reg != '0) && disp_found;
  end

  // Pick the first reporting core at or after rep_ptr, wrapping around
  always_comb begin
    rep_found = 1'b0;
    rep_idx   = '0;
    rep_cand  = '0;
    for (int i = 0; i < NumCores; i++) begin
      rep_cand = CoreW'((int'(rep_ptr_reg) + i) % NumCores);
      if (!rep_found && report_vec[rep_cand]) begin
        rep_found = 1'b1;
        rep_idx   = rep_cand;
      end
    end
  end

  // Queue pointers, occupancy, dispatch pointer and the one-cycle start descriptor
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rr_ptr_reg    <= '0;
      start_job_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (dispatch) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        rr_ptr_reg <= (disp_idx == CoreW'(NumCores - 1)) ? '0 : disp_idx + 1'b1;
      end
      case ({push, dispatch})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      start_job_reg <= dispatch ? queue_mem[rd_ptr_reg] : '0;
    end
  end

  // Queue storage write port; no reset so it maps onto RAM
  always_ff @(posedge clk_i) begin
    if (push) queue_mem[wr_ptr_reg] <= job_data_i;
  end

  // Report channel: latch a selection when idle, release it on handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_valid_reg <= 1'b0;
      done_core_reg  <= '0;
      done_tmo_reg   <= 1'b0;
      rep_ptr_reg    <= '0;
    end else if (release_rep) begin
      done_valid_reg <= 1'b0;
      rep_ptr_reg    <= (done_core_reg == CoreW'(NumCores - 1)) ? '0 : done_core_reg + 1'b1;
    end else if (!done_valid_reg && rep_found) begin
      done_valid_reg <= 1'b1;
      done_core_reg  <= rep_idx;
      done_tmo_reg   <= tmo_vec[rep_idx];
    end
  end

  for (genvar gi = 0; gi < NumCores; gi++) begin : g_core
    core_state_t             state_reg, state_next;
    logic [TimeoutWidth-1:0] run_cnt_reg, run_cnt_next;
    logic                    tmo_flag_reg, tmo_flag_next;
    logic                    tmo_hit, abort_pulse;

    // The counter holds the number of RUN cycles already completed
    assign tmo_hit = (timeout_i != '0) && (run_cnt_reg == timeout_i - 1'b1);

    assign core_start_o[gi] = (state_reg == START);
    assign core_abort_o[gi] = abort_pulse;
    assign idle_vec[gi]     = (state_reg == IDLE);
    assign report_vec[gi]   = (state_reg == REPORT);
    assign tmo_vec[gi]      = tmo_flag_reg;

    // Core state, run counter and timeout flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg    <= IDLE;
        run_cnt_reg  <= '0;
        tmo_flag_reg <= 1'b0;
      end else begin
        state_reg    <= state_next;
        run_cnt_reg  <= run_cnt_next;
        tmo_flag_reg <= tmo_flag_next;
      end
    end

    // Core lifecycle; a done in the timeout cycle takes priority over the abort
    always_comb begin
      state_next    = state_reg;
      run_cnt_next  = run_cnt_reg;
      tmo_flag_next = tmo_flag_reg;
      abort_pulse   = 1'b0;
      case (state_reg)
        IDLE: begin
          if (dispatch && (disp_idx == CoreW'(gi))) state_next = START;
        end
        START: begin
          state_next   = RUN;
          run_cnt_next = '0;
        end
        RUN: begin
          if (core_done_i[gi]) begin
            state_next    = REPORT;
            tmo_flag_next = 1'b0;
          end else if (tmo_hit) begin
            state_next    = REPORT;
            tmo_flag_next = 1'b1;
            abort_pulse   = 1'b1;
          end else if (run_cnt_reg != '1) begin
            run_cnt_next = run_cnt_reg + 1'b1;
          end
        end
        REPORT: begin
          if (release_rep && (done_core_reg == CoreW'(gi))) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ising_job_sched.sv
// Self-checking bench for ising_job_sched: directed scenarios plus a random
// soak, every cycle compared against a queue/array based reference model.
module tb_ising_job_sched;
  localparam int NC = 4;
  localparam int JW = 32;
  localparam int QD = 4;
  localparam int TW = 16;
  localparam int CNT_MAX = (1 << TW) - 1;
  localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_REPORT = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic [TW-1:0] timeout_i = '0;
  logic          job_valid_i = 1'b0;
  logic          job_ready_o;
  logic [JW-1:0] job_data_i = '0;
  logic [NC-1:0] core_start_o;
  logic [JW-1:0] core_job_o;
  logic [NC-1:0] core_abort_o;
  logic [NC-1:0] core_done_i = '0;
  logic          done_valid_o;
  logic          done_ready_i = 1'b0;
  logic [1:0]    done_core_o;
  logic          done_timeout_o;
  logic [2:0]    queue_cnt_o;
  logic          idle_o;

  ising_job_sched #(.NumCores(NC), .JobWidth(JW), .QueueDepth(QD), .TimeoutWidth(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .timeout_i(timeout_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_data_i(job_data_i),
    .core_start_o(core_start_o), .core_job_o(core_job_o), .core_abort_o(core_abort_o),
    .core_done_i(core_done_i), .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_core_o(done_core_o), .done_timeout_o(done_timeout_o),
    .queue_cnt_o(queue_cnt_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  // Reference model: job list, per-core phase and elapsed RUN cycles, report slot
  logic [JW-1:0] mq[$];
  int            ph[NC];
  int            el[NC];
  bit            tm[NC];
  int            rr, rp, dcore;
  bit            dv, dtmo;
  logic [JW-1:0] sjob;

  // Observation logs
  int            st_core[$], st_cyc[$], ab_core[$], ab_cyc[$], rp_core[$], rp_tmo[$];
  logic [JW-1:0] st_job[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int oh2idx(input logic [NC-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NC; k++) if (v[k] && r < 0) r = k;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      ph[k] = P_IDLE; el[k] = 0; tm[k] = 1'b0;
    end
    mq.delete();
    rr = 0; rp = 0; dv = 1'b0; dcore = 0; dtmo = 1'b0; sjob = '0;
  endtask

  function automatic bit timed_out(input int k);
    int done_runs;
    done_runs = (el[k] < CNT_MAX) ? el[k] : CNT_MAX;
    return (ph[k] == P_RUN) && !core_done_i[k] && (timeout_i != 0) &&
           (done_runs + 1 == int'(timeout_i));
  endfunction

  task automatic model_update();
    int  nph[NC];
    int  dk, sel, rel_core;
    bit  rel, push_ok;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    push_ok = job_valid_i && (mq.size() < QD);
    dk = -1;
    if (en_i && mq.size() > 0)
      for (int i = 0; i < NC; i++)
        if (dk < 0 && ph[(rr + i) % NC] == P_IDLE) dk = (rr + i) % NC;
    rel = dv && done_ready_i;
    rel_core = dcore;
    if (rel) begin
      dv = 1'b0;
      rp = (rel_core + 1) % NC;
    end else if (!dv) begin
      sel = -1;
      for (int i = 0; i < NC; i++)
        if (sel < 0 && ph[(rp + i) % NC] == P_REPORT) sel = (rp + i) % NC;
      if (sel >= 0) begin
        dv = 1'b1; dcore = sel; dtmo = tm[sel];
      end
    end
    for (int k = 0; k < NC; k++) begin
      nph[k] = ph[k];
      if (ph[k] == P_IDLE && k == dk) nph[k] = P_START;
      else if (ph[k] == P_START) begin
        nph[k] = P_RUN; el[k] = 0;
      end else if (ph[k] == P_RUN) begin
        if (core_done_i[k]) begin
          nph[k] = P_REPORT; tm[k] = 1'b0;
        end else if (timed_out(k)) begin
          nph[k] = P_REPORT; tm[k] = 1'b1;
        end else el[k]++;
      end else if (ph[k] == P_REPORT && rel && k == rel_core) nph[k] = P_IDLE;
    end
    for (int k = 0; k < NC; k++) ph[k] = nph[k];
    if (dk >= 0) begin
      sjob = mq.pop_front();
      rr = (dk + 1) % NC;
    end else sjob = '0;
    if (push_ok) mq.push_back(job_data_i);
  endtask

  task automatic compare_outputs();
    logic [NC-1:0] e_start, e_abort;
    bit            all_idle;
    e_start = '0; e_abort = '0; all_idle = 1'b1;
    for (int k = 0; k < NC; k++) begin
      if (ph[k] == P_START) e_start[k] = 1'b1;
      if (ph[k] != P_IDLE) all_idle = 1'b0;
      if (timed_out(k)) e_abort[k] = 1'b1;
    end
    check_val("job_ready", job_ready_o, mq.size() < QD);
    check_val("core_start", core_start_o, e_start);
    check_val("core_job", core_job_o, sjob);
    check_val("core_abort", core_abort_o, e_abort);
    check_val("queue_cnt", queue_cnt_o, mq.size());
    check_val("idle", idle_o, all_idle && mq.size() == 0);
    check_val("done_valid", done_valid_o, dv);
    if (dv) begin
      check_val("done_core", done_core_o, dcore);
      check_val("done_timeout", done_timeout_o, dtmo);
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    compare_outputs();
    if (core_start_o != '0) begin
      st_core.push_back(oh2idx(core_start_o));
      st_job.push_back(core_job_o);
      st_cyc.push_back(cyc);
    end
    for (int k = 0; k < NC; k++)
      if (core_abort_o[k]) begin
        ab_core.push_back(k);
        ab_cyc.push_back(cyc);
      end
    if (done_valid_o && done_ready_i) begin
      rp_core.push_back(int'(done_core_o));
      rp_tmo.push_back(int'(done_timeout_o));
      $display("report: core %0d timeout %0d cycle %0d", done_core_o, done_timeout_o, cyc);
    end
    @(posedge clk_i);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, job_ready_o, 1'b1);
    check_val({tag, "_start"}, core_start_o, '0);
    check_val({tag, "_job"}, core_job_o, '0);
    check_val({tag, "_abort"}, core_abort_o, '0);
    check_val({tag, "_dvalid"}, done_valid_o, 1'b0);
    check_val({tag, "_dcore"}, done_core_o, '0);
    check_val({tag, "_dtmo"}, done_timeout_o, 1'b0);
    check_val({tag, "_qcnt"}, queue_cnt_o, '0);
    check_val({tag, "_idle"}, idle_o, 1'b1);
  endtask

  task automatic clear_logs();
    st_core.delete(); st_job.delete(); st_cyc.delete();
    ab_core.delete(); ab_cyc.delete(); rp_core.delete(); rp_tmo.delete();
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    en_i = 1'b0; job_valid_i = 1'b0; core_done_i = '0; done_ready_i = 1'b0; timeout_i = '0;
    model_reset();
    repeat (2) cycle();
    check_reset_outputs("rst");
    rst_ni = 1'b1;
    clear_logs();
  endtask

  task automatic push_jobs(input int n, input logic [JW-1:0] base);
    for (int i = 0; i < n; i++) begin
      job_valid_i = 1'b1;
      job_data_i = base + JW'(i);
      cycle();
    end
    job_valid_i = 1'b0;
  endtask

  initial begin
    int s2, a2, found;

    // Six jobs back-to-back: cores 0..3 start in consecutive cycles, two stay queued
    apply_reset();
    en_i = 1'b1;
    push_jobs(6, 32'hA000_0000);
    cycle();
    check_val("s1_nstarts", st_core.size(), 4);
    if (st_core.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check_val("s1_core", st_core[i], i);
        check_val("s1_job", st_job[i], 32'hA000_0000 + i);
        check_val("s1_consec", st_cyc[i] - st_cyc[0], i);
      end
    check_val("s1_qcnt", queue_cnt_o, 2);

    // Fill with dispatch disabled, then push against a full queue while popping
    apply_reset();
    push_jobs(5, 32'hB000_0000);
    check_val("s2_qcnt_full", queue_cnt_o, 4);
    check_val("s2_ready_full", job_ready_o, 1'b0);
    en_i = 1'b1; job_valid_i = 1'b1; job_data_i = 32'hB000_00FF;
    cycle();
    check_val("s2_full_push_rejected", queue_cnt_o, 3);
    cycle();
    check_val("s2_push_pop_same", queue_cnt_o, 3);
    job_valid_i = 1'b0;

    // Timeout of 10 with no done: abort on the 10th RUN cycle, reported as timeout
    apply_reset();
    en_i = 1'b1; timeout_i = 16'd10; done_ready_i = 1'b1;
    push_jobs(3, 32'hC000_0000);
    for (int i = 0; i < 60 && rp_core.size() < 3; i++) cycle();
    check_val("s3_nreports", rp_core.size(), 3);
    s2 = -100; a2 = -1;
    foreach (st_core[i]) if (st_core[i] == 2) s2 = st_cyc[i];
    foreach (ab_core[i]) if (ab_core[i] == 2) a2 = ab_cyc[i];
    check_val("s3_abort_cycle", a2 - s2, 10);
    found = 0;
    foreach (rp_core[i]) if (rp_core[i] == 2 && rp_tmo[i] == 1) found = 1;
    check_val("s3_core2_timeout_report", found, 1);

    // Cores 1 and 3 finish together: core 1 held while not ready, then core 3
    apply_reset();
    en_i = 1'b1;
    push_jobs(4, 32'hD000_0000);
    repeat (6) cycle();
    core_done_i = 4'b1010;
    cycle();
    core_done_i = '0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      check_val("s4_hold_valid", done_valid_o, 1'b1);
      check_val("s4_hold_core", done_core_o, 1);
      cycle();
    end
    done_ready_i = 1'b1;
    for (int i = 0; i < 20 && rp_core.size() < 2; i++) cycle();
    check_val("s4_nreports", rp_core.size(), 2);
    if (rp_core.size() == 2) begin
      check_val("s4_first", rp_core[0], 1);
      check_val("s4_second", rp_core[1], 3);
    end

    // Done in the same cycle as the timeout: done wins, no abort
    apply_reset();
    en_i = 1'b1; timeout_i = 16'd5; done_ready_i = 1'b1;
    push_jobs(1, 32'hE000_0000);
    for (int i = 0; i < 10 && st_core.size() < 1; i++) cycle();
    check_val("s5_started", st_core.size(), 1);
    repeat (4) cycle();
    core_done_i = 4'b0001;
    cycle();
    core_done_i = '0;
    for (int i = 0; i < 10 && rp_core.size() < 1; i++) cycle();
    check_val("s5_no_abort", ab_core.size(), 0);
    check_val("s5_nreports", rp_core.size(), 1);
    if (rp_core.size() == 1) check_val("s5_tmo_flag", rp_tmo[0], 0);

    // Reset with two cores running and three jobs queued
    apply_reset();
    en_i = 1'b1;
    push_jobs(2, 32'hF000_0000);
    repeat (4) cycle();
    en_i = 1'b0;
    push_jobs(3, 32'hF000_0010);
    check_val("s6_qcnt", queue_cnt_o, 3);
    check_val("s6_busy", idle_o, 1'b0);
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("s6_async");
    repeat (2) cycle();
    rst_ni = 1'b1;
    en_i = 1'b1;
    repeat (3) cycle();
    check_val("s6_idle_after", idle_o, 1'b1);

    // Random soak with a mid-run reset
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) timeout_i = TW'($urandom_range(0, 12));
      en_i = ($urandom % 8) != 0;
      job_valid_i = $urandom % 2;
      job_data_i = $urandom;
      for (int k = 0; k < NC; k++) core_done_i[k] = ($urandom % 6) == 0;
      done_ready_i = ($urandom % 10) < 7;
      if (n == 700) begin
        rst_ni = 1'b0;
        model_reset();
      end
      if (n == 702) rst_ni = 1'b1;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
